// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, default
// baud divisor and the frame-length helper.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Clock cycles for which busy stays high for one complete frame.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned data_width,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
    return clks_per_bit * (1 + data_width + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Clearing on frame accept aligns the first bit period to the accept edge.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1 or 2
// stop bits. tx, busy and tx_ready are all driven straight from flops.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tx_start,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_ready,
  output logic                  tx_done
);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_serializer: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e           state, state_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic                  parity_q, parity_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic                  stop_cnt, stop_cnt_n;
  logic                  tx_q, tx_n;
  logic                  busy_q, busy_n;
  logic                  ready_q;
  logic                  baud_clear;
  logic                  tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      parity_q  <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      parity_q  <= parity_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      tx_q      <= tx_n;
      busy_q    <= busy_n;
      ready_q   <= ~busy_n;
    end
  end

  // tx_n is the line level for the cycle after the edge, so every bit change
  // is decided at the transition that enters the new bit.
  always_comb begin
    state_n    = state;
    shift_n    = shift_reg;
    parity_n   = parity_q;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    tx_n       = tx_q;
    busy_n     = busy_q;
    baud_clear = 1'b0;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_start) begin
          state_n    = START;
          shift_n    = data_in;
          parity_n   = (^data_in) ^ 1'(PARITY_ODD);
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          baud_clear = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          tx_n    = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = parity_q;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            shift_n   = shift_reg >> 1;
            tx_n      = shift_n[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            state_n    = IDLE;
            stop_cnt_n = 1'b0;
            busy_n     = 1'b0;
            tx_done    = 1'b1;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks
// per bit, checked cycle by cycle against a frame-bit-list model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] start;
  logic [7:0] din [4];
  wire  [3:0] tx;
  wire  [3:0] busy;
  wire  [3:0] rdy;
  wire  [3:0] done;

  int pe_t  [4] = '{0, 1, 1, 0};
  int odd_t [4] = '{0, 0, 1, 0};
  int sb_t  [4] = '{1, 1, 1, 2};

  int vectors = 0;
  int errors  = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_n  (.clk(clk), .rst(rst), .data_in(din[0]), .tx_start(start[0]),
          .tx(tx[0]), .busy(busy[0]), .tx_ready(rdy[0]), .tx_done(done[0]));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_pe (.clk(clk), .rst(rst), .data_in(din[1]), .tx_start(start[1]),
          .tx(tx[1]), .busy(busy[1]), .tx_ready(rdy[1]), .tx_done(done[1]));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_po (.clk(clk), .rst(rst), .data_in(din[2]), .tx_start(start[2]),
          .tx(tx[2]), .busy(busy[2]), .tx_ready(rdy[2]), .tx_done(done[2]));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_s2 (.clk(clk), .rst(rst), .data_in(din[3]), .tx_start(start[3]),
          .tx(tx[3]), .busy(busy[3]), .tx_ready(rdy[3]), .tx_done(done[3]));

  // Idle-line check for one instance at the current sample point.
  task automatic check_idle(input int i, input string name);
    vectors++;
    if ({tx[i], busy[i], rdy[i], done[i]} !== 4'b1010) begin
      errors++;
      $display("FAIL %s inst%0d: tx/busy/rdy/done=%b%b%b%b expected 1010",
               name, i, tx[i], busy[i], rdy[i], done[i]);
    end
  endtask

  // Sends one word on instance i and checks every cycle of the frame plus the
  // idle cycle after it. glitch_at >= 0 pulses tx_start with 8'hFF mid-frame.
  // Called and returning at a negedge sample point.
  task automatic send_frame(input int i, input logic [7:0] d, input int glitch_at);
    logic exp_q [$];
    int   ones;
    int   f;
    exp_q = {};
    exp_q.push_back(1'b0);
    ones = 0;
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(d[b]);
      ones += int'(d[b]);
    end
    if (pe_t[i] != 0) exp_q.push_back(1'((ones + odd_t[i]) % 2));
    for (int s = 0; s < sb_t[i]; s++) exp_q.push_back(1'b1);
    f = exp_q.size() * CPB;

    start[i] = 1'b1;
    din[i]   = d;
    @(posedge clk);
    @(negedge clk);
    start[i] = 1'b0;
    din[i]   = 8'($urandom);
    for (int k = 0; k < f; k++) begin
      vectors++;
      if (tx[i] !== exp_q[k / CPB]) begin
        errors++;
        $display("FAIL frame_tx inst%0d data=%h cycle %0d: tx=%b expected %b", i, d, k, tx[i], exp_q[k / CPB]);
      end
      vectors++;
      if (busy[i] !== 1'b1 || rdy[i] !== 1'b0) begin
        errors++;
        $display("FAIL frame_busy inst%0d cycle %0d: busy=%b rdy=%b expected 1 0", i, k, busy[i], rdy[i]);
      end
      vectors++;
      if (done[i] !== (k == f - 1)) begin
        errors++;
        $display("FAIL frame_done inst%0d cycle %0d: tx_done=%b expected %b", i, k, done[i], k == f - 1);
      end
      if (k == glitch_at) begin
        start[i] = 1'b1;
        din[i]   = 8'hFF;
      end else begin
        start[i] = 1'b0;
      end
      @(negedge clk);
    end
    start[i] = 1'b0;
    check_idle(i, "frame_end");
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check_idle(i, "gap");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check_idle(i, "reset_hold");
    end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    send_frame(0, 8'hA5, -1);
    idle_cycles(2);
    for (int n = 0; n < 4; n++) begin
      send_frame(0, 8'($urandom), -1);
      idle_cycles($urandom_range(0, 3));
    end
  endtask

  task automatic test_parity();
    send_frame(1, 8'h07, -1);
    idle_cycles(1);
    send_frame(2, 8'h07, -1);
    idle_cycles(1);
    for (int n = 0; n < 6; n++) begin
      send_frame($urandom_range(1, 2), 8'($urandom), -1);
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  task automatic test_stop2();
    send_frame(3, 8'h00, 20);
    idle_cycles(1);
    send_frame(3, 8'($urandom), $urandom_range(0, 40));
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    send_frame(0, 8'($urandom), -1);
    send_frame(0, 8'h3C, -1);
    send_frame(2, 8'($urandom), -1);
    send_frame(2, 8'($urandom), -1);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    int saw_done;
    saw_done = 0;
    start[0] = 1'b1;
    din[0]   = 8'h55;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    // Cycles 16..19 carry data bit 3; reset is applied during cycle 17.
    for (int k = 0; k < 18; k++) begin
      if (done[0] === 1'b1) saw_done = 1;
      if (k < 17) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || saw_done != 0) begin
      errors++;
      $display("FAIL reset_mid: tx=%b busy=%b done=%b saw_done=%0d expected 1 0 0 0",
               tx[0], busy[0], done[0], saw_done);
    end
    idle_cycles(2);
    send_frame(0, 8'h81, -1);
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
